pong_match_ctrl: RTL and testbench

- Match sequencer for the two-paddle pong game.
- Owns the score register and the game phase.
- Drives the shared control strobes consumed by both paddle blocks, the ball block and the pixel renderer: recenter (guiwei), serve start, run enable.
- Turns raw point events from the ball block into an IDLE → SERVE → PLAY → POINT → OVER flow, with pause support.

---
 rtl/pong_match_ctrl_if.sv | 25 ++
 rtl/pong_match_ctrl.sv | 145 ++++++++++++++
 tb/tb_pong_match_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// Game-control bundle between the match sequencer and its environment:
// point/button/frame inputs in, shared strobes, score and phase out.
interface pong_match_ctrl_if;
  logic       i_frame_tick;
  logic       i_start_btn;
  logic       i_pause_btn;
  logic       i_point_l;
  logic       i_point_r;
  logic       o_guiwei;
  logic       o_serve;
  logic       o_run_en;
  logic [3:0] o_score;
  logic [1:0] o_winner;
  logic [2:0] o_phase;

  modport master (
    output i_frame_tick, i_start_btn, i_pause_btn, i_point_l, i_point_r,
    input  o_guiwei, o_serve, o_run_en, o_score, o_winner, o_phase
  );

  modport slave (
    input  i_frame_tick, i_start_btn, i_pause_btn, i_point_l, i_point_r,
    output o_guiwei, o_serve, o_run_en, o_score, o_winner, o_phase
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: IDLE -> SERVE -> PLAY -> POINT -> OVER with pause,
// owning the scores and the shared recenter/serve/run strobes.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int CNT_W        = 7
) (
  input  logic              i_vga_clk,
  input  logic              i_sys_rst,
  pong_match_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4,
    PAUSE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [1:0]       WIN_LVL    = 2'(WIN_SCORE);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [1:0]       r_score_l, w_score_l_next;
  logic [1:0]       r_score_r, w_score_r_next;
  logic [1:0]       r_winner, w_winner_next;
  logic             r_guiwei, w_guiwei_next;
  logic             r_serve, w_serve_next;
  logic             r_run_en, w_run_en_next;
  logic             r_start_q, r_pause_q, r_armed;
  logic             w_start_rise, w_pause_rise, w_tick_last;
  logic             w_left_won, w_right_won;

  // r_armed masks the first cycle after reset so a button held through
  // reset is seen as already high rather than as a fresh press.
  assign w_start_rise = r_armed & bus.i_start_btn & ~r_start_q;
  assign w_pause_rise = r_armed & bus.i_pause_btn & ~r_pause_q;
  assign w_tick_last  = bus.i_frame_tick && (r_cnt <= CNT_ONE);
  assign w_left_won   = (r_score_l >= WIN_LVL);
  assign w_right_won  = (r_score_r >= WIN_LVL);

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_score_l_next = r_score_l;
    w_score_r_next = r_score_r;
    w_winner_next  = r_winner;
    w_guiwei_next  = 1'b0;
    w_serve_next   = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (w_start_rise) begin
          w_state_next   = SERVE;
          w_score_l_next = 2'd0;
          w_score_r_next = 2'd0;
          w_winner_next  = 2'b00;
          w_cnt_next     = SERVE_LOAD;
          w_guiwei_next  = 1'b1;
        end
      end
      SERVE: begin
        if (w_tick_last) begin
          w_cnt_next   = '0;
          w_state_next = PLAY;
          w_serve_next = 1'b1;
        end else if (bus.i_frame_tick) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      PLAY: begin
        // A point outranks a pause request arriving in the same cycle.
        if (bus.i_point_l || bus.i_point_r) begin
          if (bus.i_point_l && r_score_l != 2'd3) w_score_l_next = r_score_l + 2'd1;
          if (bus.i_point_r && r_score_r != 2'd3) w_score_r_next = r_score_r + 2'd1;
          w_state_next = POINT;
          w_cnt_next   = POINT_LOAD;
        end else if (w_pause_rise) begin
          w_state_next = PAUSE;
        end
      end
      POINT: begin
        if (w_tick_last) begin
          w_cnt_next = '0;
          if (w_left_won || w_right_won) begin
            w_state_next  = OVER;
            w_winner_next = {w_left_won, w_right_won};
          end else begin
            w_state_next  = SERVE;
            w_cnt_next    = SERVE_LOAD;
            w_guiwei_next = 1'b1;
          end
        end else if (bus.i_frame_tick) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      PAUSE: begin
        if (w_pause_rise) w_state_next = PLAY;
      end
      default: w_state_next = IDLE;
    endcase
    w_run_en_next = (w_state_next == PLAY);
  end

  always_ff @(posedge i_vga_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_score_l <= 2'd0;
      r_score_r <= 2'd0;
      r_winner  <= 2'b00;
      r_guiwei  <= 1'b0;
      r_serve   <= 1'b0;
      r_run_en  <= 1'b0;
      r_start_q <= 1'b0;
      r_pause_q <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_score_l <= w_score_l_next;
      r_score_r <= w_score_r_next;
      r_winner  <= w_winner_next;
      r_guiwei  <= w_guiwei_next;
      r_serve   <= w_serve_next;
      r_run_en  <= w_run_en_next;
      r_start_q <= bus.i_start_btn;
      r_pause_q <= bus.i_pause_btn;
      r_armed   <= 1'b1;
    end
  end

  assign bus.o_phase  = r_state;
  assign bus.o_score  = {r_score_l, r_score_r};
  assign bus.o_winner = r_winner;
  assign bus.o_guiwei = r_guiwei;
  assign bus.o_serve  = r_serve;
  assign bus.o_run_en = r_run_en;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: directed match scenarios followed by random
// play, every cycle compared with a behavioural match model.
module tb_pong_match_ctrl;
  localparam int WIN = 3;
  localparam int SF  = 2;
  localparam int PF  = 3;
  localparam int CW  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pong_match_ctrl_if bus ();

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .CNT_W(CW)
  ) dut (
    .i_vga_clk(clk),
    .i_sys_rst(rst),
    .bus(bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model of the match: phase number, two integer scores, frames left.
  int   m_phase, m_left, m_right, m_frames;
  logic [1:0] m_win;
  bit   m_guiwei, m_serve, m_run;
  bit   m_start_prev, m_pause_prev;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_right = 0; m_frames = 0; m_win = 2'b00;
    m_guiwei = 0; m_serve = 0; m_run = 0;
    // Buttons already high at release must not count as presses.
    m_start_prev = 1; m_pause_prev = 1;
  endtask

  task automatic model_clock(input bit tick, input bit st, input bit pa, input bit pl, input bit pr);
    bit srise, prise;
    srise = st && !m_start_prev;
    prise = pa && !m_pause_prev;
    m_start_prev = st;
    m_pause_prev = pa;
    m_guiwei = 0;
    m_serve  = 0;
    if (m_phase == 0 || m_phase == 4) begin
      if (srise) begin
        m_left = 0; m_right = 0; m_win = 2'b00; m_frames = SF; m_guiwei = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (tick) begin
        m_frames = m_frames - 1;
        if (m_frames == 0) begin m_phase = 2; m_serve = 1; end
      end
    end else if (m_phase == 2) begin
      if (pl || pr) begin
        if (pl) m_left  = (m_left  < 3) ? m_left + 1  : 3;
        if (pr) m_right = (m_right < 3) ? m_right + 1 : 3;
        m_phase = 3; m_frames = PF;
      end else if (prise) m_phase = 5;
    end else if (m_phase == 3) begin
      if (tick) begin
        m_frames = m_frames - 1;
        if (m_frames == 0) begin
          if (m_left >= WIN || m_right >= WIN) begin
            m_phase = 4;
            m_win = {m_left >= WIN, m_right >= WIN};
          end else begin
            m_phase = 1; m_frames = SF; m_guiwei = 1;
          end
        end
      end
    end else if (m_phase == 5) begin
      if (prise) m_phase = 2;
    end
    m_run = (m_phase == 2);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".phase"},  8'(bus.o_phase),  8'(m_phase));
    check({tag, ".score"},  8'(bus.o_score),  8'(m_left * 4 + m_right));
    check({tag, ".winner"}, 8'(bus.o_winner), 8'(m_win));
    check({tag, ".guiwei"}, 8'(bus.o_guiwei), 8'(m_guiwei));
    check({tag, ".serve"},  8'(bus.o_serve),  8'(m_serve));
    check({tag, ".run_en"}, 8'(bus.o_run_en), 8'(m_run));
    $display("%t %s phase=%0d score=%b winner=%b guiwei=%b serve=%b run_en=%b", $time, tag,
             bus.o_phase, bus.o_score, bus.o_winner, bus.o_guiwei, bus.o_serve, bus.o_run_en);
  endtask

  task automatic step(input string tag, input bit tick, input bit st, input bit pa,
                      input bit pl, input bit pr);
    bus.i_frame_tick = tick;
    bus.i_start_btn  = st;
    bus.i_pause_btn  = pa;
    bus.i_point_l    = pl;
    bus.i_point_r    = pr;
    @(posedge clk);
    model_clock(tick, st, pa, pl, pr);
    #1 check_all(tag);
    @(negedge clk);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1, 0, 0, 0, 0);
  endtask

  initial begin
    bit st, pa;
    bus.i_frame_tick = 0; bus.i_start_btn = 1; bus.i_pause_btn = 0;
    bus.i_point_l = 0; bus.i_point_r = 0;
    model_reset();
    #23 check_all("reset");
    @(negedge clk);
    rst = 0;
    // Start held through reset release: no transition.
    for (int k = 0; k < 3; k++) step("held_start", 0, 1, 0, 0, 0);
    check("held_start.phase", 8'(bus.o_phase), 8'd0);

    step("release", 0, 0, 0, 0, 0);
    step("start", 0, 1, 0, 0, 0);
    check("start.guiwei", 8'(bus.o_guiwei), 8'd1);
    step("start_hold", 0, 1, 0, 0, 0);
    check("guiwei_one_cycle", 8'(bus.o_guiwei), 8'd0);
    step("serve1", 1, 0, 0, 0, 0);
    step("serve2", 1, 0, 0, 0, 0);
    check("launch.serve", 8'(bus.o_serve), 8'd1);
    check("launch.phase", 8'(bus.o_phase), 8'd2);

    step("point_l", 0, 0, 0, 1, 0);
    check("point_l.score", 8'(bus.o_score), 8'h04);
    check("point_l.run_en", 8'(bus.o_run_en), 8'd0);
    ticks("point_wait", PF);
    check("reserve.phase", 8'(bus.o_phase), 8'd1);
    check("reserve.guiwei", 8'(bus.o_guiwei), 8'd1);

    // Left reaches 3 points and wins.
    for (int p = 0; p < 2; p++) begin
      ticks("serve_wait", SF);
      step("point_l", 0, 0, 0, 1, 0);
      ticks("point_wait", PF);
    end
    check("over.phase", 8'(bus.o_phase), 8'd4);
    check("over.winner", 8'(bus.o_winner), 8'b10);
    ticks("over_hold", 2);
    check("over.score_held", 8'(bus.o_score[3:2]), 8'd3);
    step("restart", 0, 1, 0, 0, 0);
    step("restart_rel", 0, 0, 0, 0, 0);
    check("restart.score", 8'(bus.o_score), 8'd0);
    check("restart.winner", 8'(bus.o_winner), 8'd0);
    check("restart.phase", 8'(bus.o_phase), 8'd1);

    // Pause and ignored point.
    ticks("serve_wait", SF);
    step("pause", 0, 0, 1, 0, 0);
    check("pause.phase", 8'(bus.o_phase), 8'd5);
    step("pause_point_r", 0, 0, 1, 0, 1);
    check("pause.score", 8'(bus.o_score), 8'd0);
    step("pause_rel", 1, 1, 0, 0, 0);
    step("unpause", 0, 0, 1, 0, 0);
    check("unpause.run_en", 8'(bus.o_run_en), 8'd1);
    step("unpause_rel", 0, 0, 0, 0, 0);

    // Simultaneous points up to a draw.
    for (int p = 0; p < 3; p++) begin
      step("both", 0, 0, 0, 1, 1);
      ticks("point_wait", PF);
      if (p < 2) ticks("serve_wait", SF);
    end
    check("draw.score", 8'(bus.o_score), 8'hF);
    check("draw.winner", 8'(bus.o_winner), 8'b11);

    // Asynchronous reset in the middle of POINT.
    step("restart", 0, 1, 0, 0, 0);
    ticks("serve_wait", SF);
    step("point_l", 0, 0, 0, 1, 0);
    #2 rst = 1;
    #1 model_reset();
    check_all("async_rst");
    check("async_rst.phase", 8'(bus.o_phase), 8'd0);
    @(negedge clk);
    rst = 0;

    // Random play against the model.
    st = 0; pa = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1;
        #1 model_reset();
        check_all("rand_rst");
        @(negedge clk);
        rst = 0;
      end
      if ($urandom_range(0, 19) == 0) st = ~st;
      if ($urandom_range(0, 24) == 0) pa = ~pa;
      step("rand", $urandom_range(0, 1) == 1, st, pa,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
